// File: rtl/adc_capture_sequencer_if.sv
// Control/status bundle between the ADC datapath/CSR side (master) and the
// capture sequencer (slave).
interface adc_capture_sequencer_if #(
  parameter int SUM_WIDTH = 16,
  parameter int LEN_WIDTH = 32
);
  logic [SUM_WIDTH-1:0] sum_in;
  logic [63:0]          sample_in;
  logic [SUM_WIDTH-1:0] cfg_level;
  logic [SUM_WIDTH-1:0] cfg_hyst;
  logic [LEN_WIDTH-1:0] cfg_min_len;
  logic [LEN_WIDTH-1:0] cfg_max_len;
  logic [LEN_WIDTH-1:0] cfg_holdoff;
  logic [15:0]          cfg_max_records;
  logic                 arm;
  logic                 abort;
  logic                 capture_en;
  logic                 rec_start;
  logic                 rec_end;
  logic                 clear_max;
  logic [2:0]           state;
  logic [63:0]          trig_sample;
  logic [63:0]          release_sample;
  logic [15:0]          record_count;
  logic [31:0]          samples_sent;
  logic                 done;

  modport master (
    output sum_in, sample_in, cfg_level, cfg_hyst, cfg_min_len, cfg_max_len,
           cfg_holdoff, cfg_max_records, arm, abort,
    input  capture_en, rec_start, rec_end, clear_max, state, trig_sample,
           release_sample, record_count, samples_sent, done
  );
  modport slave (
    input  sum_in, sample_in, cfg_level, cfg_hyst, cfg_min_len, cfg_max_len,
           cfg_holdoff, cfg_max_records, arm, abort,
    output capture_en, rec_start, rec_end, clear_max, state, trig_sample,
           release_sample, record_count, samples_sent, done
  );
endinterface

// File: rtl/adc_capture_sequencer.sv
// Arm -> trigger -> capture -> holdoff sequencer gating ADC stream capture.
// All outputs are registered; the sample seen on the trigger edge is record sample 1.
module adc_capture_sequencer #(
  parameter int SUM_WIDTH = 16,
  parameter int LEN_WIDTH = 32
) (
  input logic                    aclk,
  input logic                    aresetn,
  adc_capture_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_HOLDOFF = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [SUM_WIDTH-1:0] level_q, level_d, lo_q, lo_d;
  logic [LEN_WIDTH-1:0] min_len_q, min_len_d, max_len_q, max_len_d;
  logic [LEN_WIDTH-1:0] holdoff_q, holdoff_d;
  logic [15:0]          max_rec_q, max_rec_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, hold_cnt_q, hold_cnt_d;
  logic [15:0]          rec_cnt_q, rec_cnt_d;
  logic [31:0]          sent_q, sent_d;
  logic [63:0]          trig_q, trig_d, rel_q, rel_d;
  logic                 cap_q, cap_d, rs_q, rs_d, re_q, re_d;
  logic                 clr_q, clr_d, done_q, done_d;

  logic [SUM_WIDTH:0]   lo_wide;
  logic [LEN_WIDTH-1:0] len_nxt;
  logic                 end_hit;

  assign lo_wide = {1'b0, bus.cfg_level} - {1'b0, bus.cfg_hyst};
  // End decision is made one edge early so rec_end lands on the last capture_en cycle.
  assign len_nxt = (state_q == S_ARMED) ? LEN_WIDTH'(1) : len_q + LEN_WIDTH'(1);
  assign end_hit = (len_nxt == max_len_q) ||
                   ((len_nxt >= min_len_q) && (bus.sum_in < lo_q));

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lo_d       = lo_q;
    min_len_d  = min_len_q;
    max_len_d  = max_len_q;
    holdoff_d  = holdoff_q;
    max_rec_d  = max_rec_q;
    len_d      = len_q;
    hold_cnt_d = hold_cnt_q;
    rec_cnt_d  = rec_cnt_q;
    sent_d     = sent_q;
    trig_d     = trig_q;
    rel_d      = rel_q;
    cap_d      = 1'b0;
    rs_d       = 1'b0;
    re_d       = 1'b0;
    clr_d      = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (bus.arm) begin
          state_d   = S_ARMED;
          level_d   = bus.cfg_level;
          lo_d      = lo_wide[SUM_WIDTH] ? '0 : lo_wide[SUM_WIDTH-1:0];
          min_len_d = bus.cfg_min_len;
          max_len_d = (bus.cfg_max_len == '0) ? LEN_WIDTH'(1) : bus.cfg_max_len;
          holdoff_d = bus.cfg_holdoff;
          max_rec_d = bus.cfg_max_records;
          rec_cnt_d = '0;
          sent_d    = '0;
          trig_d    = '0;
          rel_d     = '0;
          clr_d     = 1'b1;
        end
        S_ARMED: if (bus.sum_in > level_q) begin
          state_d = S_CAPTURE;
          trig_d  = bus.sample_in;
          if (rec_cnt_q != 16'hFFFF) rec_cnt_d = rec_cnt_q + 16'd1;
          len_d   = len_nxt;
          cap_d   = 1'b1;
          rs_d    = 1'b1;
          if (end_hit) begin
            re_d  = 1'b1;
            rel_d = bus.sample_in;
          end
        end
        S_CAPTURE: begin
          if (re_q) begin
            if ((max_rec_q != '0) && (rec_cnt_q == max_rec_q)) begin
              state_d = S_DONE;
            end else if (holdoff_q == '0) begin
              state_d = S_ARMED;
            end else begin
              state_d    = S_HOLDOFF;
              hold_cnt_d = LEN_WIDTH'(1);
            end
          end else begin
            len_d = len_nxt;
            cap_d = 1'b1;
            if (end_hit) begin
              re_d  = 1'b1;
              rel_d = bus.sample_in;
            end
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt_q >= holdoff_q) state_d = S_ARMED;
          else hold_cnt_d = hold_cnt_q + LEN_WIDTH'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (cap_d && (sent_q != 32'hFFFF_FFFF)) sent_d = sent_q + 32'd1;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      lo_q       <= '0;
      min_len_q  <= '0;
      max_len_q  <= '0;
      holdoff_q  <= '0;
      max_rec_q  <= '0;
      len_q      <= '0;
      hold_cnt_q <= '0;
      rec_cnt_q  <= '0;
      sent_q     <= '0;
      trig_q     <= '0;
      rel_q      <= '0;
      cap_q      <= 1'b0;
      rs_q       <= 1'b0;
      re_q       <= 1'b0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      lo_q       <= lo_d;
      min_len_q  <= min_len_d;
      max_len_q  <= max_len_d;
      holdoff_q  <= holdoff_d;
      max_rec_q  <= max_rec_d;
      len_q      <= len_d;
      hold_cnt_q <= hold_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
      sent_q     <= sent_d;
      trig_q     <= trig_d;
      rel_q      <= rel_d;
      cap_q      <= cap_d;
      rs_q       <= rs_d;
      re_q       <= re_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
    end
  end

  assign bus.capture_en     = cap_q;
  assign bus.rec_start      = rs_q;
  assign bus.rec_end        = re_q;
  assign bus.clear_max      = clr_q;
  assign bus.state          = state_q;
  assign bus.trig_sample    = trig_q;
  assign bus.release_sample = rel_q;
  assign bus.record_count   = rec_cnt_q;
  assign bus.samples_sent   = sent_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench: per-cycle vector tables plus hand sequences for holdoff and async reset.
module tb_adc_capture_sequencer;
  typedef struct {
    logic        arm;
    logic        abort;
    logic [15:0] sum;
    logic        cap;
    logic        rs;
    logic        re;
    logic        clr;
    logic [2:0]  st;
    logic        dn;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] smp = 64'd0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          row = 0;
  vec_t        tbl[$];

  adc_capture_sequencer_if #(.SUM_WIDTH(16), .LEN_WIDTH(32)) bus ();
  adc_capture_sequencer #(.SUM_WIDTH(16), .LEN_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input int lvl, input int hyst, input int mn, input int mx,
                         input int hold, input int recs);
    bus.cfg_level       = 16'(lvl);
    bus.cfg_hyst        = 16'(hyst);
    bus.cfg_min_len     = 32'(mn);
    bus.cfg_max_len     = 32'(mx);
    bus.cfg_holdoff     = 32'(hold);
    bus.cfg_max_records = 16'(recs);
  endtask

  task automatic step(input logic a, input logic ab, input logic [15:0] s);
    bus.arm       = a;
    bus.abort     = ab;
    bus.sum_in    = s;
    bus.sample_in = smp;
    smp           = smp + 64'd1;
    @(posedge aclk);
    #1;
  endtask

  function automatic vec_t v(input int a, input int ab, input int s, input int cap,
                             input int rs, input int re, input int clr, input int st,
                             input int dn);
    vec_t r;
    r.arm = a[0]; r.abort = ab[0]; r.sum = s[15:0];
    r.cap = cap[0]; r.rs = rs[0]; r.re = re[0]; r.clr = clr[0];
    r.st = st[2:0]; r.dn = dn[0];
    return r;
  endfunction

  task automatic run_tbl();
    foreach (tbl[i]) begin
      step(tbl[i].arm, tbl[i].abort, tbl[i].sum);
      chk($sformatf("r%0d capture_en", row), 64'(bus.capture_en), 64'(tbl[i].cap));
      chk($sformatf("r%0d rec_start", row),  64'(bus.rec_start),  64'(tbl[i].rs));
      chk($sformatf("r%0d rec_end", row),    64'(bus.rec_end),    64'(tbl[i].re));
      chk($sformatf("r%0d clear_max", row),  64'(bus.clear_max),  64'(tbl[i].clr));
      chk($sformatf("r%0d state", row),      64'(bus.state),      64'(tbl[i].st));
      chk($sformatf("r%0d done", row),       64'(bus.done),       64'(tbl[i].dn));
      row++;
    end
    tbl.delete();
  endtask

  initial begin
    bus.arm = 1'b0; bus.abort = 1'b0; bus.sum_in = '0; bus.sample_in = '0;
    set_cfg(0, 0, 0, 0, 0, 0);
    #12;
    chk("reset capture_en",   64'(bus.capture_en),   64'd0);
    chk("reset state",        64'(bus.state),        64'd0);
    chk("reset record_count", 64'(bus.record_count), 64'd0);
    chk("reset samples_sent", 64'(bus.samples_sent), 64'd0);
    chk("reset trig_sample",  bus.trig_sample,       64'd0);
    chk("reset done",         64'(bus.done),         64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Basic record: 8 samples, trigger on sample 50, single record then DONE
    set_cfg(100, 0, 0, 8, 0, 1);
    smp = 64'd48;
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 0,   0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 200, 1, 1, 0, 0, 2, 0));
    for (int k = 0; k < 6; k++) tbl.push_back(v(0, 0, 200, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 200, 1, 0, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 200, 0, 0, 0, 0, 4, 1));
    tbl.push_back(v(0, 0, 100, 0, 0, 0, 0, 4, 1));
    run_tbl();
    chk("basic trig_sample",    bus.trig_sample,          64'd50);
    chk("basic release_sample", bus.release_sample,       64'd57);
    chk("basic record_count",   64'(bus.record_count),    64'd1);
    chk("basic samples_sent",   64'(bus.samples_sent),    64'd8);

    // Early release with hysteresis: lo = 80, min_len = 3
    set_cfg(100, 20, 3, 100, 0, 0);
    smp = 64'd100;
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 150, 1, 1, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 150, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 90,  1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 70,  1, 0, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 0,   0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 100, 0, 0, 0, 0, 1, 0));
    run_tbl();
    chk("hyst trig_sample",    bus.trig_sample,       64'd101);
    chk("hyst release_sample", bus.release_sample,    64'd104);
    chk("hyst record_count",   64'(bus.record_count), 64'd1);
    chk("hyst samples_sent",   64'(bus.samples_sent), 64'd4);
    tbl.push_back(v(0, 0, 150, 1, 1, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 10,  1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 10,  1, 0, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 0,   0, 0, 0, 0, 1, 0));
    run_tbl();
    chk("minlen trig_sample",    bus.trig_sample,       64'd107);
    chk("minlen release_sample", bus.release_sample,    64'd109);
    chk("minlen record_count",   64'(bus.record_count), 64'd2);
    chk("minlen samples_sent",   64'(bus.samples_sent), 64'd7);

    // Holdoff = 5: 2-sample records repeat every 8 cycles with 6 idle cycles between
    set_cfg(100, 0, 0, 2, 5, 0);
    step(1'b0, 1'b1, 16'd0);
    step(1'b1, 1'b0, 16'd0);
    chk("holdoff arm state", 64'(bus.state), 64'd1);
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 1'b0, 16'd200);
      chk($sformatf("holdoff c%0d capture_en", i), 64'(bus.capture_en),
          64'(((i - 1) % 8) < 2));
      chk($sformatf("holdoff c%0d rec_start", i), 64'(bus.rec_start),
          64'(((i - 1) % 8) == 0));
      if (((i - 1) % 8) == 0)
        chk($sformatf("holdoff c%0d record_count", i), 64'(bus.record_count),
            64'((i - 1) / 8 + 1));
    end
    chk("holdoff samples_sent", 64'(bus.samples_sent), 64'd6);

    // Abort on the 3rd capture cycle, then arm+abort together
    set_cfg(100, 0, 0, 10, 0, 0);
    tbl.push_back(v(0, 1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 200, 1, 1, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 200, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 200, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 1, 200, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 200, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0,   0, 0, 0, 0, 0, 0));
    run_tbl();
    chk("abort record_count", 64'(bus.record_count), 64'd1);
    chk("abort samples_sent", 64'(bus.samples_sent), 64'd3);

    // Re-arm during CAPTURE is ignored
    set_cfg(100, 0, 0, 4, 0, 0);
    tbl.push_back(v(1, 0, 0,   0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 200, 1, 1, 0, 0, 2, 0));
    tbl.push_back(v(1, 0, 200, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 200, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 0, 200, 1, 0, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 0,   0, 0, 0, 0, 1, 0));
    run_tbl();
    chk("rearm record_count", 64'(bus.record_count), 64'd1);
    chk("rearm samples_sent", 64'(bus.samples_sent), 64'd4);

    // max_len = 0 gives 1-sample records; later cfg changes are not latched
    set_cfg(100, 0, 0, 0, 0, 0);
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0));
    run_tbl();
    set_cfg(250, 0, 0, 8, 0, 0);
    tbl.push_back(v(0, 0, 200, 1, 1, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 200, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 200, 1, 1, 1, 0, 2, 0));
    tbl.push_back(v(0, 0, 0,   0, 0, 0, 0, 1, 0));
    run_tbl();
    chk("len1 record_count", 64'(bus.record_count), 64'd2);
    chk("len1 samples_sent", 64'(bus.samples_sent), 64'd2);

    // Async reset in the middle of a record
    set_cfg(100, 0, 0, 8, 0, 0);
    step(1'b0, 1'b1, 16'd0);
    step(1'b1, 1'b0, 16'd0);
    step(1'b0, 1'b0, 16'd200);
    step(1'b0, 1'b0, 16'd200);
    chk("pre-reset capture_en", 64'(bus.capture_en), 64'd1);
    #3;
    aresetn = 1'b0;
    #1;
    chk("async capture_en",   64'(bus.capture_en),   64'd0);
    chk("async rec_start",    64'(bus.rec_start),    64'd0);
    chk("async state",        64'(bus.state),        64'd0);
    chk("async record_count", 64'(bus.record_count), 64'd0);
    chk("async samples_sent", 64'(bus.samples_sent), 64'd0);
    chk("async trig_sample",  bus.trig_sample,       64'd0);
    #2;
    aresetn = 1'b1;
    step(1'b0, 1'b0, 16'd200);
    chk("post-reset state",      64'(bus.state),      64'd0);
    chk("post-reset capture_en", 64'(bus.capture_en), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Sequences trigger-driven capture windows for the ADC front end. Consumes the per-sample absolute-sum magnitude and the sample counter from the ADC datapath. Runs an arm → trigger → capture → holdoff cycle and drives a capture-enable that gates the AXI-Stream `tvalid` of the ADC output. Software sees timestamped record boundaries and counters; record length, hysteresis, holdoff and record budget are all configurable.

## Interface
Parameters:
- `SUM_WIDTH`, 16: width of magnitude input and thresholds.
- `LEN_WIDTH`, 32: width of length and holdoff counters.

Ports:
- `aclk` in 1: single clock; all logic on rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `sum_in` in SUM_WIDTH: unsigned magnitude, one new value per cycle.
- `sample_in` in 64: sample counter aligned with `sum_in`.
- `cfg_level` in SUM_WIDTH: trigger threshold (strictly greater fires).
- `cfg_hyst` in SUM_WIDTH: release hysteresis below level.
- `cfg_min_len` in LEN_WIDTH: minimum captured samples before early release.
- `cfg_max_len` in LEN_WIDTH: maximum captured samples per record; 0 treated as 1.
- `cfg_holdoff` in LEN_WIDTH: cycles in HOLDOFF after each record.
- `cfg_max_records` in 16: records per arm; 0 means unlimited.
- `arm` in 1: start pulse.
- `abort` in 1: stop pulse.
- `capture_en` out 1: high on every sample belonging to a record.
- `rec_start` out 1: one-cycle strobe on the first `capture_en` cycle of a record.
- `rec_end` out 1: one-cycle strobe on the last `capture_en` cycle of a record.
- `clear_max` out 1: one-cycle pulse to reset the datapath peak tracker, issued on arm.
- `state` out 3: IDLE=0, ARMED=1, CAPTURE=2, HOLDOFF=3, DONE=4.
- `trig_sample` out 64: `sample_in` of the most recent trigger cycle.
- `release_sample` out 64: `sample_in` of the most recent `rec_end` cycle.
- `record_count` out 16: records started since arm; saturates at 0xFFFF.
- `samples_sent` out 32: `capture_en` cycles since arm; saturates.
- `done` out 1: high while in DONE.

## Operation
- Reset: state IDLE; all outputs 0; config shadow registers 0.
- Config latch: all `cfg_*` inputs are copied into shadow registers on an accepted `arm`. Changes to `cfg_*` after that are ignored until the next arm.
- Release threshold: `lo = level − hyst`, computed at SUM_WIDTH+1 bits and saturated at 0.
- Effective maximum length: `max_len_eff = max(cfg_max_len, 1)`.

State transitions:
- IDLE: `arm` → ARMED. Clears `record_count`, `samples_sent`, `trig_sample` and `release_sample`, and pulses `clear_max`.
- ARMED: `sum_in > level` → CAPTURE. Latches `trig_sample = sample_in`, increments `record_count`, clears the length counter.
- CAPTURE:
  - `capture_en` is high.
  - The length counter `n` counts captured samples, starting at 1.
  - Record ends on the cycle where `n == max_len_eff`, or where `n >= cfg_min_len && sum_in < lo`.
  - On that end cycle: assert `rec_end`, latch `release_sample`.
  - Next state: DONE if `cfg_max_records != 0 && record_count == cfg_max_records`. Otherwise HOLDOFF, or ARMED directly if `cfg_holdoff == 0`.
- HOLDOFF: counts `cfg_holdoff` cycles, then → ARMED. Triggers are ignored in this state.
- DONE: `done` is high. `arm` restarts exactly as from IDLE.
- `abort`: from any state → IDLE on the next edge. `capture_en` drops immediately, with no `rec_end`. Counters are retained.

Simultaneous and ignored events:
- `arm` together with `abort`: abort wins.
- `arm` in ARMED, CAPTURE or HOLDOFF: ignored.
- `cfg_min_len > max_len_eff`: `max_len_eff` governs.

## Timing
- All outputs are registered.
- Trigger seen on `sum_in` at edge N: `state` = CAPTURE after edge N. `capture_en` and `rec_start` are high in cycle N+1. `trig_sample` = `sample_in` of cycle N.
- A record with no early release holds `capture_en` high for exactly `max_len_eff` consecutive cycles.
- `rec_end` coincides with the last `capture_en` cycle.
- The earliest re-trigger is evaluated on the first ARMED cycle, which is `cfg_holdoff` + 1 cycles after `rec_end`.
- `clear_max` is high in the cycle following the accepted `arm`.
- `done` rises the cycle after the final `rec_end`.
- `aresetn` asserted mid-record: `capture_en` falls asynchronously; all state returns to reset values.

## Test plan
- Basic record: arm with level=100, hyst=0, min=0, max_len=8, holdoff=0, max_records=1; drive `sum_in`=200 at the cycle with sample 50. Required: `capture_en` high for 8 cycles; `trig_sample`=50; `record_count`=1; `samples_sent`=8; `done`=1.
- Early release with hysteresis: level=100, hyst=20, min_len=3, max_len=100; `sum_in` 150, 150, 90, 70. Required: no end at 90 (90 ≥ 80); record ends on the 70 cycle, n=4; `rec_end` there.
- Holdoff: holdoff=5, max_records=0; `sum_in` held at 200. Required: successive records separated by exactly 6 non-capture cycles; `record_count` increments per record.
- Abort mid-capture: abort on the 3rd capture cycle. Required: `capture_en`=0 next cycle; no `rec_end`; state IDLE; counters held.
- Arm with abort, and arm while busy: `arm`+`abort` in the same cycle leaves the block in IDLE. Re-arm while in CAPTURE has no effect on counters. `cfg_max_len`=0 yields 1-sample records.
- Async reset mid-record: assert `aresetn`=0 during CAPTURE. Required: all outputs 0 immediately; state IDLE after release.
